// File: rtl/arb_pkg.sv
// Shared types and constants for the unified SRAM port arbiter.
// Holds the response-owner encoding, read write-enable code and starve width.
package arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } owner_e;

    localparam logic [3:0] WEN_READ = 4'b0000;
    localparam int         STARVE_W = 2;

endpackage

// File: rtl/arb_resp_tracker.sv
// Tracks which requester owns the in-flight SRAM read and routes the
// response. Ports: grants/wen in, sram_rdata in, rvalid/rdata per side out.
module arb_resp_tracker
    import arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_gnt,
    input  logic              data_gnt,
    input  logic [3:0]        data_wen,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata
);

    owner_e            r_owner;
    owner_e            w_owner_nxt;
    logic [DATA_W-1:0] r_inst_hold;
    logic [DATA_W-1:0] r_data_hold;

    // Writes return nothing, so only reads claim the next response slot.
    always_comb begin
        w_owner_nxt = NONE;
        unique case (1'b1)
            inst_gnt: w_owner_nxt = INST;
            data_gnt: w_owner_nxt = (data_wen == WEN_READ) ? DATA : NONE;
            default:  w_owner_nxt = NONE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner     <= NONE;
            r_inst_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (r_owner == INST) r_inst_hold <= sram_rdata;
            if (r_owner == DATA) r_data_hold <= sram_rdata;
        end
    end

    assign inst_rvalid = (r_owner == INST);
    assign data_rvalid = (r_owner == DATA);

    // Live SRAM data in the response cycle, captured copy afterwards.
    assign inst_rdata = inst_rvalid ? sram_rdata : r_inst_hold;
    assign data_rdata = data_rvalid ? sram_rdata : r_data_hold;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port 1-cycle SRAM between inst fetch and data access.
// Ports: inst/data request+grant+response, SRAM en/wen/addr/wdata/rdata.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve;
    logic                w_both;
    logic                w_inst_win;
    logic                w_data_win;

    // Data normally has priority; inst is forced through once starved.
    assign w_both     = inst_req & data_req;
    assign w_inst_win = inst_req & (~data_req | (r_starve == STARVE_LIM));
    assign w_data_win = data_req & ~w_inst_win;

    assign inst_gnt = w_inst_win & resetn;
    assign data_gnt = w_data_win & resetn;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = WEN_READ;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            inst_gnt: begin
                sram_en   = 1'b1;
                sram_addr = inst_addr;
            end
            data_gnt: begin
                sram_en    = 1'b1;
                sram_wen   = data_wen;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    // Counts consecutive contended cycles lost by inst; saturating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (w_both && w_data_win) begin
            if (r_starve != '1) r_starve <= r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    arb_resp_tracker #(
        .DATA_W(DATA_W)
    ) u_resp (
        .clk        (clk),
        .resetn     (resetn),
        .inst_gnt   (inst_gnt),
        .data_gnt   (data_gnt),
        .data_wen   (data_wen),
        .sram_rdata (sram_rdata),
        .inst_rvalid(inst_rvalid),
        .inst_rdata (inst_rdata),
        .data_rvalid(data_rvalid),
        .data_rdata (data_rdata)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with an SRAM model and
// a behavioural reference for arbitration, memory contents and responses.
module tb_sram_port_arbiter;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_val(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 0) return 32'h3C1D8000;
        return {b, 8'hA5, ~b, 8'h3C};
    endfunction

    // SRAM behaviour: 64 words, read data one cycle after the address.
    logic [31:0] mem [64];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem[sram_addr[7:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b])
                        mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        int          due;
        logic [31:0] d;
    } resp_t;

    resp_t       iq[$];
    resp_t       dq[$];
    logic [31:0] ref_mem [64];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          mstarve = 0;
    logic        g_i = 1'b0;
    logic        g_d = 1'b0;
    logic [31:0] ihold = '0;
    logic [31:0] dhold = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: pops the expected response due this cycle, else
    // expects no rvalid and the previously returned data held.
    always @(negedge clk) begin
        if (!resetn) begin
            iq.delete();
            dq.delete();
            ihold = '0;
            dhold = '0;
        end else begin
            if (iq.size() > 0 && iq[0].due == cyc_n) begin
                chk("inst_rvalid", 32'(inst_rvalid), 32'd1);
                chk("inst_rdata", inst_rdata, iq[0].d);
                ihold = iq[0].d;
                void'(iq.pop_front());
            end else begin
                chk("inst_rvalid_idle", 32'(inst_rvalid), 32'd0);
                chk("inst_rdata_hold", inst_rdata, ihold);
            end
            if (dq.size() > 0 && dq[0].due == cyc_n) begin
                chk("data_rvalid", 32'(data_rvalid), 32'd1);
                chk("data_rdata", data_rdata, dq[0].d);
                dhold = dq[0].d;
                void'(dq.pop_front());
            end else begin
                chk("data_rvalid_idle", 32'(data_rvalid), 32'd0);
                chk("data_rdata_hold", data_rdata, dhold);
            end
        end
    end

    // One cycle of stimulus plus reference-model prediction.
    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
        logic        iw;
        logic        dwn;
        logic [31:0] ea;
        resp_t       r;
        @(posedge clk);
        #1;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wen   = dw;
        data_addr  = da;
        data_wdata = dd;
        @(negedge clk);
        iw  = ir && (!dr || mstarve == SMAX);
        dwn = dr && !iw;
        ea  = iw ? ia : (dwn ? da : 32'h0);
        chk("inst_gnt", 32'(inst_gnt), 32'(iw));
        chk("data_gnt", 32'(data_gnt), 32'(dwn));
        chk("sram_en", 32'(sram_en), 32'(iw || dwn));
        chk("sram_addr", sram_addr, ea);
        chk("sram_wen", 32'(sram_wen), dwn ? 32'(dw) : 32'h0);
        if (!iw) chk("sram_wdata", sram_wdata, dwn ? dd : 32'h0);
        mstarve = (ir && dr && dwn) ? ((mstarve < SMAX) ? mstarve + 1 : SMAX) : 0;
        if (iw) begin
            r.due = cyc_n + 1;
            r.d   = ref_mem[ia[7:2]];
            iq.push_back(r);
        end
        if (dwn) begin
            if (dw == 4'b0000) begin
                r.due = cyc_n + 1;
                r.d   = ref_mem[da[7:2]];
                dq.push_back(r);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (dw[b]) ref_mem[da[7:2]][8*b +: 8] = dd[8*b +: 8];
            end
        end
        g_i = iw;
        g_d = dwn;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rand_run(input int n);
        logic        pi;
        logic        pd;
        logic [31:0] ra;
        logic [31:0] rda;
        logic [31:0] rdd;
        logic [3:0]  rdw;
        pi = 1'b0;
        pd = 1'b0;
        ra = '0; rda = '0; rdd = '0; rdw = '0;
        for (int k = 0; k < n; k++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1'b1;
                ra = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
            end
            if (!pd && $urandom_range(0, 3) != 0) begin
                pd  = 1'b1;
                rda = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
                rdd = $urandom;
                rdw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            cyc(pi, ra, pd, rdw, rda, rdd);
            if (g_i) pi = 1'b0;
            if (g_d) pd = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        // Reset: grants and responses quiet even with requests high.
        inst_req = 1'b1;
        data_req = 1'b1;
        #1;
        chk("rst_inst_gnt", 32'(inst_gnt), 32'd0);
        chk("rst_data_gnt", 32'(data_gnt), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
        chk("rst_data_rvalid", 32'(data_rvalid), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // Boot fetch, then hold after rvalid drops.
        cyc(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();

        // Full-word write, no response; then immediate read-back.
        cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h80001000, 32'hDEADBEEF);
        idle();
        cyc(1'b0, 32'h0, 1'b1, 4'h3, 32'h80001004, 32'h12345678);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h80001004, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h80001000, 32'h0);
        idle();

        // Contention: data wins three times, then inst is forced in.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h00000010, 1'b1, 4'h0, 32'h00000020, 32'h0);
            chk("contend_data_win", 32'(data_gnt), 32'd1);
        end
        cyc(1'b1, 32'h00000010, 1'b1, 4'h0, 32'h00000020, 32'h0);
        chk("starve_inst_gnt", 32'(inst_gnt), 32'd1);
        chk("starve_data_gnt", 32'(data_gnt), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h00000020, 32'h0);
        idle();

        // Back-to-back inst then data read.
        cyc(1'b1, 32'h00000044, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h00000048, 32'h0);
        idle();
        idle();

        rand_run(400);
        idle();

        // Reset while a data response is pending.
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h00000014, 32'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_data_rvalid", 32'(data_rvalid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_data_rvalid", 32'(data_rvalid), 32'd0);
        chk("mid_rst_data_rdata", data_rdata, 32'd0);
        chk("mid_rst_inst_rdata", inst_rdata, 32'd0);
        chk("mid_rst_sram_en", 32'(sram_en), 32'd0);
        chk("mid_rst_data_gnt", 32'(data_gnt), 32'd0);
        mstarve = 0;
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        idle();
        rand_run(200);
        idle();
        idle();
        @(negedge clk);
        chk("drain_empty", 32'(iq.size() + dq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
